// File: rtl/reg_wr_arbiter_pkg.sv
// Shared constants and helpers for the register write-port arbiter.
// Optional burst locking is enabled with URCPU_ARB_LOCK_EN.
package reg_wr_arbiter_pkg;

    localparam int unsigned GRANT_ID_W = 3;
    localparam int unsigned NREQ_DEF   = 4;
    localparam int unsigned NREG_DEF   = 8;
    localparam int unsigned AW_DEF     = 3;
    localparam int unsigned DW_DEF     = 8;

    // Round-robin successor of idx among nreq requesters.
    function automatic logic [GRANT_ID_W-1:0] next_ptr(input logic [GRANT_ID_W-1:0] idx,
                                                       input int unsigned nreq);
        if (32'(idx) >= nreq - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/reg_wr_arbiter_if.sv
// Request/write-back bus between requesters, the arbiter and the dff bank.
// The lock vector exists only when URCPU_ARB_LOCK_EN is defined.
interface reg_wr_arbiter_if
    import reg_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) ();

    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    wr_addr;
    logic [NREQ*DW-1:0]    wr_data;
`ifdef URCPU_ARB_LOCK_EN
    logic [NREQ-1:0]       lock;
`endif
    logic [NREQ-1:0]       ack;
    logic [NREG-1:0]       reg_we;
    logic [DW-1:0]         reg_d;
    logic [GRANT_ID_W-1:0] grant_id;
    logic                  err_oob;

    modport master (
`ifdef URCPU_ARB_LOCK_EN
        output lock,
`endif
        output req, wr_addr, wr_data,
        input  ack, reg_we, reg_d, grant_id, err_oob
    );

    modport slave (
`ifdef URCPU_ARB_LOCK_EN
        input  lock,
`endif
        input  req, wr_addr, wr_data,
        output ack, reg_we, reg_d, grant_id, err_oob
    );

endinterface

// File: rtl/reg_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or above ptr,
// wrapping to 0. Reusable by other arbiters.
module rr_pick
    import reg_wr_arbiter_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]          eligible,
    input  logic [GRANT_ID_W-1:0] ptr,
    output logic                  valid,
    output logic [GRANT_ID_W-1:0] idx
);

    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        // Walk from the farthest candidate back to ptr so the nearest one wins.
        for (int k = int'(N) - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % int'(N);
            if (eligible[j]) begin
                valid = 1'b1;
                idx   = j[GRANT_ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing one dff register bank among NREQ writers.
// Defining URCPU_ARB_LOCK_EN adds per-requester burst locking.
module reg_wr_arbiter
    import reg_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input logic             clk,
    input logic             rst_n,
    reg_wr_arbiter_if.slave bus
);

    logic [GRANT_ID_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]       ack_q, ack_d;
    logic [GRANT_ID_W-1:0] grant_q, grant_d;
    logic [DW-1:0]         data_q, data_d;
    logic [NREG-1:0]       we_q, we_d;
    logic                  oob_q, oob_d;

    logic [NREQ-1:0]       ack_mask;
    logic [NREQ-1:0]       eligible;
    logic                  pick_valid;
    logic [GRANT_ID_W-1:0] pick_idx;
    logic [AW-1:0]         win_addr;
    logic                  win_lock;

    // A requester in its ack cycle is masked so it can drop or change req,
    // unless it holds lock and wants to keep bursting.
`ifdef URCPU_ARB_LOCK_EN
    assign ack_mask = ack_q & ~bus.lock;
    assign win_lock = bus.lock[pick_idx];
`else
    assign ack_mask = ack_q;
    assign win_lock = 1'b0;
`endif
    assign eligible = bus.req & ~ack_mask;

    rr_pick #(
        .N(NREQ)
    ) u_pick (
        .eligible(eligible),
        .ptr     (ptr_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    assign win_addr = bus.wr_addr[int'(pick_idx)*AW +: AW];

    always_comb begin
        ptr_d   = ptr_q;
        ack_d   = '0;
        grant_d = '0;
        data_d  = '0;
        we_d    = '0;
        oob_d   = 1'b0;
        if (pick_valid) begin
            ptr_d   = win_lock ? pick_idx : next_ptr(pick_idx, NREQ);
            ack_d   = NREQ'(1) << pick_idx;
            grant_d = pick_idx;
            data_d  = bus.wr_data[int'(pick_idx)*DW +: DW];
            if (32'(win_addr) < NREG) begin
                we_d = NREG'(1) << win_addr;
            end else begin
                oob_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            ack_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            we_q    <= '0;
            oob_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            we_q    <= we_d;
            oob_q   <= oob_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.grant_id = grant_q;
    assign bus.reg_d    = data_q;
    assign bus.reg_we   = we_q;
    assign bus.err_oob  = oob_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: two instances (NREG=8 and NREG=6) on shared inputs,
// directed scenarios then random traffic against a behavioural model.
module tb_reg_wr_arbiter;
    import reg_wr_arbiter_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] wr_addr;
    logic [NREQ*DW-1:0] wr_data;
`ifdef URCPU_ARB_LOCK_EN
    logic [NREQ-1:0]    lock;
`endif

    reg_wr_arbiter_if #(.NREQ(NREQ), .NREG(8), .AW(AW), .DW(DW)) bus8 ();
    reg_wr_arbiter_if #(.NREQ(NREQ), .NREG(6), .AW(AW), .DW(DW)) bus6 ();

    assign bus8.req     = req;
    assign bus8.wr_addr = wr_addr;
    assign bus8.wr_data = wr_data;
    assign bus6.req     = req;
    assign bus6.wr_addr = wr_addr;
    assign bus6.wr_data = wr_data;
`ifdef URCPU_ARB_LOCK_EN
    assign bus8.lock = lock;
    assign bus6.lock = lock;
`endif

    reg_wr_arbiter #(.NREQ(NREQ), .NREG(8), .AW(AW), .DW(DW)) dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus8.slave)
    );

    reg_wr_arbiter #(.NREQ(NREQ), .NREG(6), .AW(AW), .DW(DW)) dut6 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus6.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: pointer plus the outputs expected after the next edge.
    int       m_ptr;
    int       e_idx;
    logic [7:0] e_d;
    logic [7:0] e_we8;
    logic [7:0] e_we6;
    logic     e_oob6;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lock_of(input int j);
`ifdef URCPU_ARB_LOCK_EN
        return int'(lock[j]);
`else
        return j - j;
`endif
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        e_idx  = -1;
        e_d    = '0;
        e_we8  = '0;
        e_we6  = '0;
        e_oob6 = 1'b0;
    endtask

    task automatic model_step();
        int win;
        int a;
        win = -1;
        for (int k = 0; k < int'(NREQ); k++) begin
            int j;
            j = (m_ptr + k) % int'(NREQ);
            if (win < 0 && req[j] && !(j == e_idx && lock_of(j) == 0)) win = j;
        end
        if (win < 0) begin
            e_idx  = -1;
            e_d    = '0;
            e_we8  = '0;
            e_we6  = '0;
            e_oob6 = 1'b0;
        end else begin
            a      = int'(wr_addr[win*AW +: AW]);
            e_idx  = win;
            e_d    = wr_data[win*DW +: DW];
            e_we8  = 8'(1 << a);
            e_we6  = (a < 6) ? 8'(1 << a) : 8'h00;
            e_oob6 = (a >= 6);
            m_ptr  = (lock_of(win) != 0) ? win : (win + 1) % int'(NREQ);
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_ack;
        logic [31:0] exp_gid;
        exp_ack = (e_idx < 0) ? 32'd0 : 32'(1 << e_idx);
        exp_gid = (e_idx < 0) ? 32'd0 : 32'(e_idx);
        check("ack8", 32'(bus8.ack), exp_ack);
        check("gid8", 32'(bus8.grant_id), exp_gid);
        check("d8", 32'(bus8.reg_d), 32'(e_d));
        check("we8", 32'(bus8.reg_we), 32'(e_we8));
        check("oob8", 32'(bus8.err_oob), 32'd0);
        check("ack6", 32'(bus6.ack), exp_ack);
        check("d6", 32'(bus6.reg_d), 32'(e_d));
        check("we6", 32'(bus6.reg_we), 32'(e_we6));
        check("oob6", 32'(bus6.err_oob), 32'(e_oob6));
    endtask

    // Inputs are set at a falling edge; the model sees what the DUT will sample.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        req     = '0;
        wr_addr = '0;
        wr_data = '0;
`ifdef URCPU_ARB_LOCK_EN
        lock    = '0;
`endif
        do_reset();

        // Reset asserted between edges while requester 2 is being acked.
        req = 4'b0100;
        wr_addr[2*AW +: AW] = 3'd1;
        wr_data[2*DW +: DW] = 8'h3C;
        tick();
        check("mid_ack", 32'(bus8.ack), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ack", 32'(bus8.ack), 32'd0);
        check("rst_we", 32'(bus8.reg_we), 32'd0);
        check("rst_d", 32'(bus8.reg_d), 32'd0);
        check("rst_gid", 32'(bus8.grant_id), 32'd0);
        model_reset();
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Contention: all four held, rotation from pointer 0.
        req     = 4'b1111;
        wr_addr = 12'($urandom);
        wr_data = $urandom;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rot_gid", 32'(bus8.grant_id), 32'(k % 4));
        end
        req = '0;
        tick();

        // Single request.
        req = 4'b0001;
        wr_addr[0 +: AW] = 3'd5;
        wr_data[0 +: DW] = 8'hA5;
        tick();
        check("single_ack", 32'(bus8.ack), 32'h1);
        check("single_we", 32'(bus8.reg_we), 32'h20);
        check("single_d", 32'(bus8.reg_d), 32'hA5);
        req = '0;
        tick();
        check("single_idle", 32'(bus8.ack), 32'd0);

        // Wrap and skip: pointer driven to 3, then 0 and 2 pending.
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        req = 4'b0101;
        tick();
        check("wrap_g0", 32'(bus8.grant_id), 32'd0);
        tick();
        check("wrap_g2", 32'(bus8.grant_id), 32'd2);
        req = '0;
        tick();
        req = 4'b1000;
        tick();
        check("wrap_ptr3", 32'(bus8.grant_id), 32'd3);
        req = '0;
        tick();

        // Out of range on the NREG=6 instance.
        req = 4'b0010;
        wr_addr[1*AW +: AW] = 3'd7;
        tick();
        check("oob_ack", 32'(bus6.ack), 32'h2);
        check("oob_flag", 32'(bus6.err_oob), 32'd1);
        check("oob_we", 32'(bus6.reg_we), 32'd0);
        req = '0;
        tick();

`ifdef URCPU_ARB_LOCK_EN
        do_reset();
        req  = 4'b0011;
        lock = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            wr_data[0 +: DW] = 8'(k * 17 + 3);
            tick();
            check("lock_gid", 32'(bus8.grant_id), 32'd0);
            check("lock_d", 32'(bus8.reg_d), 32'(k * 17 + 3));
        end
        lock = '0;
        tick();
        check("unlock_gid", 32'(bus8.grant_id), 32'd1);
        req = '0;
        tick();
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            req     = NREQ'($urandom);
            wr_addr = 12'($urandom);
            wr_data = $urandom;
`ifdef URCPU_ARB_LOCK_EN
            lock    = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
`endif
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
